lcd_read_controller: RTL and testbench
======================================

// Module: lcd_read_controller
// PURPOSE
//  Read side of the HD44780-style 4-bit LCD bus. It complements the LCD write controller.
//  On request it runs one read cycle with RW=1: high nibble first, then low nibble.
//  It returns the byte read: busy flag + address counter when RS=0, DDRAM/CGRAM data when RS=1.
//  It sits beside the write controller. The top level gives the nibble bus to this block while lcd_bus_rd=1.
// PARAMETERS
//  T_SETUP_NS   40    RS/RW setup time before E rises (tAS)
//  T_EHIGH_NS   240   E high time; the nibble is sampled on the last clock of E high (covers tDDR=160)
//  T_GAP_NS     1000  E low time between the high and low nibble strobes
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active-low
//  period_clk_ns  in   8  clock period in ns; a value of 0 is treated as 1
//  rs_in          in   1  register select for the read; latched when the request is accepted
//  strobe_in      in   1  read request; sampled only in IDLE
//  lcd_nibble_in  in   4  LCD DB7..DB4 from the pad input buffer
//  lcd_e          out  1  LCD enable
//  lcd_rs         out  1  LCD register select (latched copy of rs_in)
//  lcd_rw         out  1  1 while a read is in progress
//  lcd_bus_rd     out  1  1 = FPGA pad drivers must be tri-stated (read owns the bus)
//  data_out       out  8  byte read; holds its value until the next done
//  busy_flag      out  1  data_out[7] when the latched RS=0, else 0
//  busy           out  1  1 from the accept edge through the done clock
//  done           out  1  one-clock pulse; data_out is valid in the same clock
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_bus_rd=0, data_out=0,
//   busy_flag=0, busy=0, done=0, counter=0, nib=0.
//  Timing counter: 11 bits, cleared on every state entry.
//   Each clock: if counter+period >= T, leave the state; otherwise counter += period.
//   Dwell = ceil(T/period) clocks.
//  FSM states:
//   IDLE: done=0. strobe_in=1 -> latch rs_in, busy=1, lcd_rw=1, lcd_bus_rd=1, nib=0 -> SETUP.
//   SETUP: lcd_e=0. After T_SETUP_NS -> E_HIGH, with lcd_e=1 registered on the exit edge.
//   E_HIGH: on the exit edge, lcd_e=0 and the nibble is sampled.
//    nib=0: data_out[7:4] <= lcd_nibble_in -> GAP.
//    nib=1: data_out[3:0] <= lcd_nibble_in, done<=1 -> DONE.
//   GAP: lcd_e=0. After T_GAP_NS -> nib=1 -> SETUP.
//   DONE: one clock. done=0, busy=0, lcd_rw=0, lcd_bus_rd=0 -> IDLE.
//  busy_flag is updated together with data_out and done.
//  Boundary conditions:
//   - strobe_in while busy: ignored, not queued.
//   - strobe_in held high: a new read starts on the first IDLE clock after DONE.
//   - rs_in and period_clk_ns changing mid-read: rs is unaffected (latched).
//     The new period applies from the next clock.
//   - lcd_e never rises while lcd_rw=0. lcd_rw and lcd_bus_rd never fall while lcd_e=1.
//   - rst mid-read: all outputs return to their reset values at once.
//     Partially read nibbles are discarded and data_out is cleared.
//  Latency at period=20 ns:
//   accept edge 0; E high edges 2-14 and 66-78.
//   done=1 for the single clock after edge 78; busy=0 after edge 79.
// CONFIGURATION
//  LCD_READ_BUSY_POLL_EN
//   Defined: adds input poll_in (1 bit), which is latched at accept and forces rs=0.
//    After the low nibble, if busy_flag=1 the block does not pulse done.
//    Instead it enters GAP and then repeats the two-nibble read.
//    done pulses only on the first read with BF=0.
//    Adds output poll_count (8 bits, saturating): reads performed in the current poll.
//    poll_count is cleared at accept and reset to 0.
//   Undefined: no poll_in or poll_count ports; every request is exactly one two-nibble read.
// TESTING
//  1. period=20, rs_in=1, strobe_in=1 for 1 clk; LCD model returns 4'hA then 4'h5.
//     -> done one clk after edge 78; data_out=8'hA5; busy_flag=0; lcd_e high 12 clks twice.
//  2. period=20, rs_in=0, model returns 4'h8 then 4'h3.
//     -> data_out=8'h83, busy_flag=1; lcd_rs=0 and lcd_rw=1 throughout.
//  3. period=100: E high 3 clks, setup 1 clk, gap 10 clks; data is sampled on the 3rd E-high clk.
//     Model drives valid data only 160 ns after E rises -> correct byte read.
//  4. Second strobe_in at edge 30 of a read -> ignored. Exactly one done; next read only on a new strobe.
//  5. rst=0 asserted while lcd_e=1 in the high nibble.
//     -> same-cycle lcd_e=0, lcd_rw=0, lcd_bus_rd=0, data_out=0, no done.
//  6. (LCD_READ_BUSY_POLL_EN) Model reports BF=1 for 2 reads, then BF=0 with AC=7'h12.
//     -> 3 reads, poll_count=3, a single done, data_out=8'h12.

Source files
------------

// File: rtl/lcd_read_controller.sv
// Read side of the HD44780-style 4-bit LCD bus: one RW=1 cycle, high nibble then low nibble.
// Optional feature macro LCD_READ_BUSY_POLL_EN: repeat reads until the busy flag clears.
module lcd_read_controller #(
    parameter int T_SETUP_NS = 40,
    parameter int T_EHIGH_NS = 240,
    parameter int T_GAP_NS   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] period_clk_ns,
    input  logic       rs_in,
    input  logic       strobe_in,
    input  logic [3:0] lcd_nibble_in,
`ifdef LCD_READ_BUSY_POLL_EN
    input  logic       poll_in,
    output logic [7:0] poll_count,
`endif
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_bus_rd,
    output logic [7:0] data_out,
    output logic       busy_flag,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HIGH,
        GAP,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [10:0] counter;
    logic        nib;
    logic [7:0]  period_eff;
    logic [11:0] count_sum;
    logic [11:0] dwell_target;
    logic        dwell_end;
    logic        repeat_read;

    assign period_eff = (period_clk_ns == 8'd0) ? 8'd1 : period_clk_ns;
    assign count_sum  = {1'b0, counter} + {4'd0, period_eff};

`ifdef LCD_READ_BUSY_POLL_EN
    logic poll_lat;
    // In poll mode RS is forced to 0, so data_out[7] is the busy flag of this read.
    assign repeat_read = poll_lat & data_out[7];
`else
    assign repeat_read = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        dwell_target = 12'd0;
        case (state)
            SETUP:   dwell_target = 12'(T_SETUP_NS);
            E_HIGH:  dwell_target = 12'(T_EHIGH_NS);
            GAP:     dwell_target = 12'(T_GAP_NS);
            default: dwell_target = 12'd0;
        endcase
        dwell_end = (count_sum >= dwell_target);
        case (state)
            IDLE:    if (strobe_in) next_state = SETUP;
            SETUP:   if (dwell_end) next_state = E_HIGH;
            E_HIGH: begin
                if (dwell_end) begin
                    if (nib && !repeat_read) next_state = DONE;
                    else                     next_state = GAP;
                end
            end
            GAP:     if (dwell_end) next_state = SETUP;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter    <= 11'd0;
            nib        <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_bus_rd <= 1'b0;
            data_out   <= 8'd0;
            busy_flag  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef LCD_READ_BUSY_POLL_EN
            poll_lat   <= 1'b0;
            poll_count <= 8'd0;
`endif
        end else begin
            // The dwell counter restarts on every state change.
            if (next_state != state) begin
                counter <= 11'd0;
            end else if (state == SETUP || state == E_HIGH || state == GAP) begin
                counter <= count_sum[10:0];
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (strobe_in) begin
                        busy       <= 1'b1;
                        lcd_rw     <= 1'b1;
                        lcd_bus_rd <= 1'b1;
                        nib        <= 1'b0;
`ifdef LCD_READ_BUSY_POLL_EN
                        lcd_rs     <= rs_in & ~poll_in;
                        poll_lat   <= poll_in;
                        poll_count <= 8'd0;
`else
                        lcd_rs     <= rs_in;
`endif
                    end
                end
                SETUP: begin
                    if (dwell_end) lcd_e <= 1'b1;
                end
                E_HIGH: begin
                    if (dwell_end) begin
                        lcd_e <= 1'b0;
                        if (!nib) begin
                            data_out[7:4] <= lcd_nibble_in;
                            busy_flag     <= ~lcd_rs & lcd_nibble_in[3];
                            nib           <= 1'b1;
                        end else begin
                            data_out[3:0] <= lcd_nibble_in;
                            busy_flag     <= ~lcd_rs & data_out[7];
`ifdef LCD_READ_BUSY_POLL_EN
                            if (poll_count != 8'hFF) poll_count <= poll_count + 8'd1;
`endif
                            if (repeat_read) nib  <= 1'b0;
                            else             done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    lcd_rw     <= 1'b0;
                    lcd_bus_rd <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_read_controller.sv
`timescale 1ns/100ps
// Bench for lcd_read_controller: table vectors, random reads against a timing/data model, corner sequences.
module tb_lcd_read_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] period_clk_ns;
    logic       rs_in;
    logic       strobe_in;
    logic [3:0] lcd_nibble_in = 4'h0;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_bus_rd, busy_flag, busy, done;
    logic [7:0] data_out;
`ifdef LCD_READ_BUSY_POLL_EN
    logic       poll_in = 1'b0;
    logic [7:0] poll_count;
`endif

    real        half_ns = 10.0;
    int         checks = 0;
    int         errors = 0;
    int         rw_violations = 0;
    logic [3:0] nib_q[$];

    typedef struct {
        int         period;
        logic       rs;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] exp_data;
        logic       exp_bf;
        int         exp_lat;
        int         exp_ehigh;
    } vec_t;

    lcd_read_controller dut (
        .clk           (clk),
        .rst           (rst),
        .period_clk_ns (period_clk_ns),
        .rs_in         (rs_in),
        .strobe_in     (strobe_in),
        .lcd_nibble_in (lcd_nibble_in),
`ifdef LCD_READ_BUSY_POLL_EN
        .poll_in       (poll_in),
        .poll_count    (poll_count),
`endif
        .lcd_e         (lcd_e),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_bus_rd    (lcd_bus_rd),
        .data_out      (data_out),
        .busy_flag     (busy_flag),
        .busy          (busy),
        .done          (done)
    );

    always #(half_ns) clk = ~clk;

    // LCD model: garbage on the bus right after E rises, the queued nibble 160 ns later.
    always @(posedge lcd_e) begin
        lcd_nibble_in = 4'($urandom);
        #160;
        if (nib_q.size() > 0) lcd_nibble_in = nib_q.pop_front();
        else                  lcd_nibble_in = 4'h0;
    end

    always @(negedge clk) begin
        if (rst && lcd_e && !(lcd_rw && lcd_bus_rd)) rw_violations++;
    end

    function automatic int ceil_div(input int t, input int p);
        return (t + p - 1) / p;
    endfunction

    function automatic int ref_latency(input int p);
        int pe;
        pe = (p == 0) ? 1 : p;
        return 2 * ceil_div(40, pe) + 2 * ceil_div(240, pe) + ceil_div(1000, pe);
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int extra_at);
        int cyc;
        int ehigh;
        int bad;
        bit seen;
        half_ns = (v.period == 0) ? 0.5 : v.period / 2.0;
        @(negedge clk);
        period_clk_ns = 8'(v.period);
        rs_in         = v.rs;
        strobe_in     = 1'b1;
        nib_q.push_back(v.hi);
        nib_q.push_back(v.lo);
        @(negedge clk);
        strobe_in = 1'b0;
        rs_in     = ~v.rs;
        cyc = 0; ehigh = 0; bad = 0; seen = 1'b0;
        while (!seen && cyc < v.exp_lat + 40) begin
            if (cyc == extra_at - 1) strobe_in = 1'b1;
            if (cyc == extra_at)     strobe_in = 1'b0;
            @(negedge clk);
            cyc++;
            if (lcd_e) ehigh++;
            if (!(lcd_rw && lcd_bus_rd && busy && (lcd_rs == v.rs))) bad++;
            if (done) seen = 1'b1;
        end
        strobe_in = 1'b0;
        check_output("latency", seen ? cyc : -1, v.exp_lat);
        check_output("data_out", int'(data_out), int'(v.exp_data));
        check_output("busy_flag", int'(busy_flag), int'(v.exp_bf));
        check_output("e_high_clks", ehigh, v.exp_ehigh);
        check_output("rw_rs_hold", bad, 0);
        @(negedge clk);
        check_output("after_done", int'({done, busy, lcd_rw, lcd_bus_rd}), 0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t r;
        int   cyc;
        int   cnt;
        bit   seen;

        vecs[0] = '{20,  1'b1, 4'hA, 4'h5, 8'hA5, 1'b0, 78,   24};
        vecs[1] = '{20,  1'b0, 4'h8, 4'h3, 8'h83, 1'b1, 78,   24};
        vecs[2] = '{100, 1'b1, 4'h3, 4'hC, 8'h3C, 1'b0, 18,   6};
        vecs[3] = '{255, 1'b0, 4'h7, 4'hE, 8'h7E, 1'b0, 8,    2};
        vecs[4] = '{0,   1'b1, 4'hF, 4'h0, 8'hF0, 1'b0, 1560, 480};
        vecs[5] = '{7,   1'b0, 4'hC, 4'h9, 8'hC9, 1'b1, 225,  70};
        vecs[6] = '{40,  1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 39,   12};

        rst = 1'b0; period_clk_ns = 8'd20; rs_in = 1'b0; strobe_in = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_ctrl", int'({lcd_e, lcd_rs, lcd_rw, lcd_bus_rd, busy_flag, busy, done}), 0);
        check_output("reset_data", int'(data_out), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], -1);

        for (int i = 0; i < 10; i++) begin
            r.period    = $urandom_range(255, 10);
            r.rs        = 1'($urandom);
            r.hi        = 4'($urandom);
            r.lo        = 4'($urandom);
            r.exp_data  = {r.hi, r.lo};
            r.exp_bf    = r.rs ? 1'b0 : r.hi[3];
            r.exp_lat   = ref_latency(r.period);
            r.exp_ehigh = 2 * ceil_div(240, r.period);
            apply_stimulus(r, -1);
        end

        // A strobe in the middle of a read is dropped, not queued.
        apply_stimulus(vecs[0], 30);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || lcd_e || done) cnt++;
        end
        check_output("ignored_strobe", cnt, 0);

        // Strobe held high: the next read starts on the first IDLE clock after DONE.
        half_ns = 10.0;
        @(negedge clk);
        period_clk_ns = 8'd20; rs_in = 1'b1; strobe_in = 1'b1;
        nib_q.push_back(4'h6); nib_q.push_back(4'h9);
        nib_q.push_back(4'h2); nib_q.push_back(4'h4);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            if (done) seen = 1'b1;
        end
        check_output("held_first_data", seen ? int'(data_out) : -1, 8'h69);
        @(negedge clk);
        check_output("held_idle_gap", int'(busy), 0);
        @(negedge clk);
        check_output("held_restart", int'(busy), 1);
        strobe_in = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk); cyc++;
            if (done) seen = 1'b1;
        end
        check_output("held_second_data", seen ? int'(data_out) : -1, 8'h24);
        @(negedge clk);

        // Reset while E is high in the high nibble.
        @(negedge clk);
        rs_in = 1'b1; strobe_in = 1'b1;
        nib_q.push_back(4'h3); nib_q.push_back(4'h7);
        @(negedge clk);
        strobe_in = 1'b0;
        repeat (4) @(negedge clk);
        check_output("e_before_reset", int'(lcd_e), 1);
        rst = 1'b0;
        #1;
        check_output("reset_mid_read", int'({lcd_e, lcd_rs, lcd_rw, lcd_bus_rd, busy, done}), 0);
        check_output("reset_mid_data", int'(data_out), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check_output("no_done_after_reset", cnt, 0);
        nib_q.delete();

`ifdef LCD_READ_BUSY_POLL_EN
        // Busy poll: BF=1 twice, then BF=0 with AC=7'h12.
        @(negedge clk);
        period_clk_ns = 8'd20; rs_in = 1'b1; poll_in = 1'b1; strobe_in = 1'b1;
        nib_q.push_back(4'h9); nib_q.push_back(4'hC);
        nib_q.push_back(4'hC); nib_q.push_back(4'h1);
        nib_q.push_back(4'h1); nib_q.push_back(4'h2);
        @(negedge clk);
        strobe_in = 1'b0; poll_in = 1'b0;
        cnt = 0; cyc = 0;
        repeat (420) begin
            @(negedge clk);
            if (done) cnt++;
            if (busy && lcd_rs) cyc++;
        end
        check_output("poll_dones", cnt, 1);
        check_output("poll_data", int'(data_out), 8'h12);
        check_output("poll_count", int'(poll_count), 3);
        check_output("poll_rs_zero", cyc, 0);
`endif

        check_output("e_implies_rw", rw_violations, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
